// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// sitting between an 8-bit CPU load/store path and a 32-bit-block memory.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-low reset
//   READ, WRITE         CPU load / store request (both high = store)
//   ADDRESS[7:0]        byte address {tag, index, offset[1:0]}
//   WRITEDATA[7:0]      store data
//   READDATA[7:0]       load data, combinational on a hit
//   BUSYWAIT            CPU stall, combinational
//   MEM_READ/MEM_WRITE  block fetch / writeback strobes
//   MEM_ADDRESS[5:0]    block address {tag, index}
//   MEM_WRITEDATA[31:0] victim block, byte0 in [7:0]
//   MEM_READDATA[31:0]  fetched block
//   MEM_BUSYWAIT        memory busy
// Optional feature macro DCACHE_STATS_EN adds HIT_COUNT/MISS_COUNT outputs.
module dcache_controller #(
    parameter int unsigned INDEX_BITS = 3
) (
`ifdef DCACHE_STATS_EN
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT,
`endif
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int unsigned SETS  = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 6 - INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FETCH, S_UPDATE} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]       valid_q, dirty_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [31:0]           data_q [SETS];
    logic [INDEX_BITS-1:0] idx_q;
    logic [TAG_W-1:0]      rtag_q, vtag_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [4:0]            bit_off;
    logic                  request, hit, idle_hit, wr_hit, rd_hit, miss_entry;

    // Address decode and hit detection
    assign idx        = ADDRESS[2 +: INDEX_BITS];
    assign tag        = ADDRESS[7 -: TAG_W];
    assign bit_off    = {ADDRESS[1:0], 3'b000};
    assign request    = READ | WRITE;
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign idle_hit   = (state_q == S_IDLE) && hit;
    assign wr_hit     = idle_hit && WRITE;
    assign rd_hit     = idle_hit && READ && !WRITE;
    assign miss_entry = (state_q == S_IDLE) && request && !hit;

    // Next-state and memory/CPU outputs
    always_comb begin
        state_d       = state_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        READDATA      = '0;
        // Gated by RESET so the stall drops the instant reset asserts
        BUSYWAIT = RESET && request && !idle_hit;
        case (state_q)
            S_IDLE: begin
                if (rd_hit) READDATA = data_q[idx][bit_off +: 8];
                if (miss_entry) state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FETCH;
            end
            S_WB: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {vtag_q, idx_q};
                MEM_WRITEDATA = data_q[idx_q];
                if (!MEM_BUSYWAIT) state_d = S_FETCH;
            end
            S_FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {rtag_q, idx_q};
                if (!MEM_BUSYWAIT) state_d = S_UPDATE;
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, valid/dirty bits and latched miss context
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            idx_q   <= '0;
            rtag_q  <= '0;
            vtag_q  <= '0;
        end else begin
            state_q <= state_d;
            if (miss_entry) begin
                idx_q  <= idx;
                rtag_q <= tag;
                vtag_q <= tag_q[idx];
            end
            if (wr_hit) dirty_q[idx] <= 1'b1;
            if (state_q == S_UPDATE) begin
                valid_q[idx_q] <= 1'b1;
                dirty_q[idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays; contents are meaningless until valid is set
    always_ff @(posedge CLK) begin
        if (wr_hit) data_q[idx][bit_off +: 8] <= WRITEDATA;
        if (state_q == S_FETCH && !MEM_BUSYWAIT) data_q[idx_q] <= MEM_READDATA;
        if (state_q == S_UPDATE) tag_q[idx_q] <= rtag_q;
    end

`ifdef DCACHE_STATS_EN
    logic        rehit_q;
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss counters; the post-fill re-hit is not a new hit
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rehit_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            rehit_q <= (state_q == S_UPDATE);
            if (idle_hit && request && !rehit_q && hit_cnt_q != 16'hFFFF)
                hit_cnt_q <= hit_cnt_q + 16'd1;
            if (miss_entry && miss_cnt_q != 16'hFFFF)
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller (INDEX_BITS=3): directed test-plan
// steps followed by random accesses, checked against a set-level cache model
// and a reference memory image.
module tb_dcache_controller;

    logic        CLK, RESET, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

    dcache_controller #(.INDEX_BITS(3)) dut (
`ifdef DCACHE_STATS_EN
        .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory responder: busy for lat-1 cycles of a request, ready on the last
    logic [31:0] mem [64];
    int mem_lat = 1;
    int cnt = 0;
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt < mem_lat - 1);
    assign MEM_READDATA = mem[MEM_ADDRESS];
    always @(posedge CLK) begin
        if ((MEM_READ | MEM_WRITE) && !MEM_BUSYWAIT) begin
            cnt <= 0;
            if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        end else if (MEM_READ | MEM_WRITE) cnt <= cnt + 1;
        else cnt <= 0;
    end

    // Reference model: per-set line state and a memory image
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] ref_mem [64];
    int          m_hits = 0, m_misses = 0;

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Predicts one access and advances the model
    task automatic model_access(input bit is_wr, input logic [7:0] a, input logic [7:0] wd,
                                input int lat, output bit hit, output bit wb,
                                output logic [5:0] wb_addr, output logic [31:0] wb_data,
                                output int stall, output logic [7:0] rd);
        int s, off;
        s   = int'(a[4:2]);
        off = int'(a[1:0]);
        hit     = m_valid[s] && (m_tag[s] == a[7:5]);
        wb      = !hit && m_valid[s] && m_dirty[s];
        wb_addr = {m_tag[s], a[4:2]};
        wb_data = m_data[s];
        stall   = hit ? 0 : (wb ? lat : 0) + lat + 2;
        if (hit) m_hits++;
        else begin
            m_misses++;
            if (wb) ref_mem[wb_addr] = m_data[s];
            m_data[s]  = ref_mem[{a[7:5], a[4:2]}];
            m_valid[s] = 1'b1;
            m_dirty[s] = 1'b0;
            m_tag[s]   = a[7:5];
        end
        if (is_wr) begin
            m_data[s][off*8 +: 8] = wd;
            m_dirty[s] = 1'b1;
        end
        rd = m_data[s][off*8 +: 8];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Drive one access, follow it to completion, compare with the model
    task automatic access(input bit is_wr, input logic [7:0] a, input logic [7:0] wd, input int lat);
        bit eh, ewb, saw_wb, saw_f, both, done;
        logic [5:0]  ewa, wa, fa;
        logic [31:0] ewd, wdat;
        logic [7:0]  erd, rd;
        int es, stall;
        saw_wb = 0; saw_f = 0; both = 0; done = 0;
        wa = '0; fa = '0; wdat = '0; rd = '0; stall = 0;
        model_access(is_wr, a, wd, lat, eh, ewb, ewa, ewd, es, erd);
        mem_lat = lat;
        @(posedge CLK); #1;
        READ = !is_wr; WRITE = is_wr; ADDRESS = a; WRITEDATA = wd;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (MEM_READ && MEM_WRITE) both = 1;
            if (MEM_WRITE && !saw_wb) begin saw_wb = 1; wa = MEM_ADDRESS; wdat = MEM_WRITEDATA; end
            if (MEM_READ && !saw_f) begin saw_f = 1; fa = MEM_ADDRESS; end
            if (!BUSYWAIT) begin done = 1; rd = READDATA; break; end
            stall++;
        end
        check("completes", 32'(done), 32'd1);
        check("stall_cycles", 32'(stall), 32'(es));
        if (!is_wr) check("readdata", 32'(rd), 32'(erd));
        check("writeback_seen", 32'(saw_wb), 32'(ewb));
        if (ewb) begin
            check("wb_address", 32'(wa), 32'(ewa));
            check("wb_data", wdat, ewd);
        end
        check("fetch_seen", 32'(saw_f), 32'(!eh));
        if (!eh) check("fetch_address", 32'(fa), 32'({a[7:5], a[4:2]}));
        check("strobes_exclusive", 32'(both), 32'd0);
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        bit seen;
        logic [7:0] ra;
        bit eh, ewb;
        logic [5:0] ewa;
        logic [31:0] ewd;
        logic [7:0] erd;
        int es;

        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h44332211;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        model_reset();

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check("rst_mem_read", 32'(MEM_READ), 32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
        check("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
        check("rst_readdata", 32'(READDATA), 32'd0);
        RESET = 1'b1;

        // Directed steps from the plan
        access(0, 8'h00, 8'h00, 3);
        access(0, 8'h03, 8'h00, 3);
        access(1, 8'h01, 8'hAA, 3);
        access(0, 8'h21, 8'h00, 3);
        access(1, 8'h45, 8'h5C, 2);
        access(0, 8'h04, 8'h00, 2);

        // Reset during FETCH of a clean miss to 0x00
        mem_lat = 5;
        @(posedge CLK); #1;
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h00;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (MEM_READ) begin seen = 1; break; end
        end
        check("fetch_before_reset", 32'(seen), 32'd1);
        RESET = 1'b0;
        #1;
        check("mid_rst_mem_read", 32'(MEM_READ), 32'd0);
        check("mid_rst_busywait", 32'(BUSYWAIT), 32'd0);
        check("mid_rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        access(0, 8'h00, 8'h00, 3);

        // Random accesses over a few tags to force conflicts and writebacks
        for (int k = 0; k < 40; k++) begin
            ra[7:5] = 3'($urandom_range(0, 3));
            ra[4:2] = 3'($urandom_range(0, 3));
            ra[1:0] = 2'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), ra, 8'($urandom), $urandom_range(1, 4));
        end

        // Request dropped mid-miss: block is still installed
        model_access(0, 8'hE8, 8'h00, 2, eh, ewb, ewa, ewd, es, erd);
        mem_lat = 2;
        @(posedge CLK); #1;
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'hE8;
        @(negedge CLK);
        check("dropped_req_busy", 32'(BUSYWAIT), 32'd1);
        @(posedge CLK); #1;
        READ = 1'b0;
        repeat (10) @(posedge CLK);
        access(0, 8'hE9, 8'h00, 2);
        idle();

        // Memory image after all writebacks
        @(negedge CLK);
        for (int i = 0; i < 64; i++) check("mem_image", mem[i], ref_mem[i]);

`ifdef DCACHE_STATS_EN
        check("hit_count", 32'(HIT_COUNT), 32'(m_hits));
        check("miss_count", 32'(MISS_COUNT), 32'(m_misses));
        access(0, 8'h00, 8'h00, 2);
        @(posedge CLK); #1;
        READ = 1'b1; ADDRESS = 8'h00;
        repeat (65540) @(posedge CLK);
        #1;
        READ = 1'b0;
        @(negedge CLK);
        check("hit_count_saturated", 32'(HIT_COUNT), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
